// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: owns the fetch PC, issues one 8-byte-aligned request at a time
// and hands instruction pairs to decode, buffering one pair across stalls.
module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        redirect,
    input  logic        stall,
    output logic [31:0] pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [63:0] inst_rdata,
    output logic        inst_rdata_1_ok,
    output logic        inst_rdata_2_ok,
    output logic [31:0] f_pc,
    output logic [31:0] f_inst_1,
    output logic [31:0] f_inst_2,
    output logic        fetch_adel
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DISCARD, HOLD} state_t;

    state_t      state;
    logic        drop;
    logic [31:0] req_addr;
    logic        req_pc2;
    logic [63:0] hold_data;

    // NOTE: req_addr, req_pc2 and hold_data are not reset; the state machine
    // never reads them until they have been written after leaving IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            state      <= IDLE;
            drop       <= 1'b0;
            fetch_adel <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this
            // block based on the pre-edge values, independent of statement order.
            pc <= next_pc;

            if (redirect)
                fetch_adel <= 1'b0;
            else if (state == IDLE && pc[1:0] != 2'b00)
                fetch_adel <= 1'b1;

            case (state)
                IDLE: begin
                    if (pc[1:0] == 2'b00 && !stall && !redirect) begin
                        req_addr <= pc;
                        req_pc2  <= ~pc[2];
                        state    <= REQ;
                    end
                end
                REQ: begin
                    // The request stays up once raised; a redirect only marks its response stale.
                    if (redirect)
                        drop <= 1'b1;
                    if (inst_addr_ok)
                        state <= (drop || redirect) ? DISCARD : WAIT;
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        if (redirect || drop) begin
                            drop  <= 1'b0;
                            state <= IDLE;
                        end else if (stall) begin
                            hold_data <= inst_rdata;
                            state     <= HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (redirect) begin
                        drop <= 1'b1;
                    end
                end
                DISCARD: begin
                    if (inst_data_ok) begin
                        drop  <= 1'b0;
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (redirect || !stall)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic        deliver;
    logic [63:0] fetch_data;

    // A redirect always suppresses delivery so next_pc never advances past a taken target.
    always_comb begin
        deliver    = 1'b0;
        fetch_data = inst_rdata;
        if (state == WAIT)
            deliver = inst_data_ok && !redirect && !stall && !drop;
        else if (state == HOLD) begin
            deliver    = !redirect && !stall;
            fetch_data = hold_data;
        end
    end

    assign inst_req        = (state == REQ);
    assign inst_addr       = {req_addr[31:3], 3'b000};
    assign inst_rdata_1_ok = deliver;
    assign inst_rdata_2_ok = deliver && req_pc2;
    assign f_pc            = req_addr;
    assign f_inst_1        = req_addr[2] ? fetch_data[63:32] : fetch_data[31:0];
    assign f_inst_2        = fetch_data[63:32];

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl; a minimal next-PC model closes the pc loop.
module tb_ifu_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] target;
    logic        stall;
    logic [31:0] pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [63:0] inst_rdata;
    logic        inst_rdata_1_ok;
    logic        inst_rdata_2_ok;
    logic [31:0] f_pc;
    logic [31:0] f_inst_1;
    logic [31:0] f_inst_2;
    logic        fetch_adel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Environment next-PC selection: redirect target, else advance by delivered count.
    assign next_pc = redirect        ? target   :
                     inst_rdata_2_ok ? pc + 32'd8 :
                     inst_rdata_1_ok ? pc + 32'd4 : pc;

    ifu_fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .next_pc         (next_pc),
        .redirect        (redirect),
        .stall           (stall),
        .pc              (pc),
        .inst_req        (inst_req),
        .inst_addr       (inst_addr),
        .inst_addr_ok    (inst_addr_ok),
        .inst_data_ok    (inst_data_ok),
        .inst_rdata      (inst_rdata),
        .inst_rdata_1_ok (inst_rdata_1_ok),
        .inst_rdata_2_ok (inst_rdata_2_ok),
        .f_pc            (f_pc),
        .f_inst_1        (f_inst_1),
        .f_inst_2        (f_inst_2),
        .fetch_adel      (fetch_adel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; target = 32'h0; stall = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 64'h0;
        repeat (2) step();

        // Reset state
        settle();
        check("rst_pc", pc, 32'hbfc00000);
        check("rst_req", {31'b0, inst_req}, 32'd0);
        check("rst_ok1", {31'b0, inst_rdata_1_ok}, 32'd0);
        check("rst_adel", {31'b0, fetch_adel}, 32'd0);
        rst = 1'b0;

        // Aligned pair fetch: IDLE, REQ, WAIT
        settle(); check("t1_idle_req", {31'b0, inst_req}, 32'd0);
        step();
        settle(); check("t1_req", {31'b0, inst_req}, 32'd1);
        check("t1_addr", inst_addr, 32'hbfc00000);
        inst_addr_ok = 1'b1; step(); inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = {32'h2, 32'h1}; settle();
        check("t1_ok1", {31'b0, inst_rdata_1_ok}, 32'd1);
        check("t1_ok2", {31'b0, inst_rdata_2_ok}, 32'd1);
        check("t1_inst1", f_inst_1, 32'h1);
        check("t1_inst2", f_inst_2, 32'h2);
        check("t1_fpc", f_pc, 32'hbfc00000);
        step(); inst_data_ok = 1'b0;
        check("t1_pc_next", pc, 32'hbfc00008);

        // Upper-word start: only one instruction delivered
        redirect = 1'b1; target = 32'hbfc00004; settle();
        check("t2_idle_redir_req", {31'b0, inst_req}, 32'd0);
        step(); redirect = 1'b0;
        step();
        settle(); check("t2_addr", inst_addr, 32'hbfc00000);
        inst_addr_ok = 1'b1; step(); inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = {32'hbbbb0001, 32'haaaa0000}; settle();
        check("t2_ok1", {31'b0, inst_rdata_1_ok}, 32'd1);
        check("t2_ok2", {31'b0, inst_rdata_2_ok}, 32'd0);
        check("t2_inst1", f_inst_1, 32'hbbbb0001);
        check("t2_fpc", f_pc, 32'hbfc00004);
        step(); inst_data_ok = 1'b0;
        check("t2_pc_next", pc, 32'hbfc00008);

        // Redirect in WAIT coinciding with data_ok
        step();
        inst_addr_ok = 1'b1; step(); inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; redirect = 1'b1; target = 32'h80001000;
        inst_rdata = {32'hdead0002, 32'hdead0001}; settle();
        check("t3_ok1", {31'b0, inst_rdata_1_ok}, 32'd0);
        step(); inst_data_ok = 1'b0; redirect = 1'b0;
        settle();
        check("t3_pc", pc, 32'h80001000);
        check("t3_idle_req", {31'b0, inst_req}, 32'd0);
        step();
        settle(); check("t3_req", {31'b0, inst_req}, 32'd1);
        check("t3_addr", inst_addr, 32'h80001000);
        inst_addr_ok = 1'b1; step(); inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = {32'h11, 32'h10}; settle();
        check("t3_ok1_after", {31'b0, inst_rdata_1_ok}, 32'd1);
        step(); inst_data_ok = 1'b0;
        check("t3_pc_next", pc, 32'h80001008);

        // Redirect in REQ with addr_ok delayed 3 cycles
        step();
        redirect = 1'b1; target = 32'h80002000; settle();
        check("t4_addr0", inst_addr, 32'h80001008);
        step(); redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("t4_req_held", {31'b0, inst_req}, 32'd1);
            check("t4_addr_held", inst_addr, 32'h80001008);
            step();
        end
        inst_addr_ok = 1'b1; settle();
        check("t4_addr_ack", inst_addr, 32'h80001008);
        step(); inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = {32'hbad1, 32'hbad0}; settle();
        check("t4_discard_ok1", {31'b0, inst_rdata_1_ok}, 32'd0);
        check("t4_pc", pc, 32'h80002000);
        step(); inst_data_ok = 1'b0;
        settle(); check("t4_idle_req", {31'b0, inst_req}, 32'd0);
        step();
        settle(); check("t4_req", {31'b0, inst_req}, 32'd1);
        check("t4_addr_target", inst_addr, 32'h80002000);

        // Stall on data arrival, held 4 cycles, then delivery from buffer
        inst_addr_ok = 1'b1; step(); inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; stall = 1'b1; inst_rdata = {32'hcccc0002, 32'hcccc0001}; settle();
        check("t5_stall_ok1", {31'b0, inst_rdata_1_ok}, 32'd0);
        step(); inst_data_ok = 1'b0; inst_rdata = {32'hffffffff, 32'heeeeeeee};
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t5_hold_ok1", {31'b0, inst_rdata_1_ok}, 32'd0);
            check("t5_hold_pc", pc, 32'h80002000);
            step();
        end
        stall = 1'b0; settle();
        check("t5_ok1", {31'b0, inst_rdata_1_ok}, 32'd1);
        check("t5_ok2", {31'b0, inst_rdata_2_ok}, 32'd1);
        check("t5_inst1", f_inst_1, 32'hcccc0001);
        check("t5_inst2", f_inst_2, 32'hcccc0002);
        check("t5_fpc", f_pc, 32'h80002000);
        step();
        check("t5_pc_next", pc, 32'h80002008);

        // Misaligned PC raises fetch_adel until the next redirect
        redirect = 1'b1; target = 32'hbfc00002; step(); redirect = 1'b0;
        step();
        settle();
        check("t6_adel", {31'b0, fetch_adel}, 32'd1);
        check("t6_no_req", {31'b0, inst_req}, 32'd0);
        step();
        settle(); check("t6_no_req2", {31'b0, inst_req}, 32'd0);
        redirect = 1'b1; target = 32'hbfc00380; step(); redirect = 1'b0;
        settle();
        check("t6_adel_clr", {31'b0, fetch_adel}, 32'd0);
        check("t6_pc", pc, 32'hbfc00380);
        check("t6_bubble", {31'b0, inst_req}, 32'd0);
        step();
        settle();
        check("t6_req", {31'b0, inst_req}, 32'd1);
        check("t6_addr", inst_addr, 32'hbfc00380);

        // Reset while a request is outstanding
        rst = 1'b1; step(); rst = 1'b0;
        settle();
        check("t7_req", {31'b0, inst_req}, 32'd0);
        check("t7_pc", pc, 32'hbfc00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Fetch-side controller feeding the next-PC logic. Owns the architectural fetch PC register and drives the instruction SRAM-like request/response handshake, with one request outstanding at a time.
- Produces the pc, inst_rdata_1_ok and inst_rdata_2_ok signals that next-PC selection consumes. Loads next_pc back every cycle.
- Presents fetched instruction pairs to the decode-side queue.
- Handles stalls with a one-entry hold buffer, and drops in-flight responses on redirects.

Parameters:
- RESET_PC, 32'hbfc00000, fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- next_pc  in  32  PC selected for the next cycle
- redirect  in  1  any of jump / branch / jr taken or exception_pc_ena this cycle
- stall  in  1  downstream queue cannot accept a pair this cycle
- pc  out  32  current fetch PC register
- inst_req  out  1  request valid
- inst_addr  out  32  request address, 8-byte aligned ({req_addr[31:3],3'b000})
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  response data valid this cycle
- inst_rdata  in  64  word0 = [31:0], word1 = [63:32]
- inst_rdata_1_ok  out  1  first instruction delivered this cycle
- inst_rdata_2_ok  out  1  second instruction delivered this cycle
- f_pc  out  32  PC of first delivered instruction
- f_inst_1  out  32  first instruction
- f_inst_2  out  32  second instruction (meaningful only with inst_rdata_2_ok)
- fetch_adel  out  1  misaligned fetch PC (pc[1:0]!=0), held until redirect

Behaviour:
- Reset (rst=1 at clk edge):
  - pc=RESET_PC; state=IDLE; drop flag=0; hold buffer empty.
  - Outputs: inst_req=0, ok outputs 0, fetch_adel=0.
- pc register: pc <= next_pc on every non-reset edge. When no ok and no redirect, next_pc equals pc, so the PC holds.
- States: IDLE, REQ, WAIT, DISCARD, HOLD.
- IDLE:
  - If pc[1:0]!=0 then fetch_adel=1 and no request is issued.
  - Else if ~stall & ~redirect, latch req_addr=pc, req_pc2=~pc[2], and go to REQ.
  - One-cycle bubble between IDLE and REQ is required.
- REQ:
  - inst_req=1. inst_addr is held from req_addr until inst_addr_ok.
  - A redirect in REQ sets the drop flag; the request is never withdrawn.
  - On inst_addr_ok: go to DISCARD if drop or redirect, else WAIT.
- WAIT, on inst_data_ok:
  - If redirect: drop the data, go to IDLE.
  - Else if stall: capture inst_rdata, req_addr and req_pc2 into the hold buffer; go to HOLD.
  - Else deliver: inst_rdata_1_ok=1; inst_rdata_2_ok=req_pc2; f_pc=req_addr; f_inst_1 = word[req_addr[2]]; f_inst_2 = word1. Go to IDLE.
- DISCARD: on inst_data_ok, drop the data, clear the drop flag, go to IDLE. No ok output is asserted.
- HOLD:
  - Redirect: empty the buffer, go to IDLE, no ok.
  - Else if ~stall: deliver from the buffer (same rules as WAIT), go to IDLE.
  - Else remain in HOLD.
- Ok outputs and f_* are combinational from state, inputs and the buffer. Ok is never asserted in the same cycle as redirect.
  - Reason: next_pc then becomes pc+4 or pc+8 only when ok is asserted.
- inst_rdata_2_ok without inst_rdata_1_ok never occurs.
- Response arriving in the same cycle as inst_addr_ok (zero-latency slave) is not supported. inst_data_ok is ignored outside WAIT and DISCARD.
- fetch_adel clears on the first redirect. The exception PC then comes through next_pc.
- Reset mid-transaction: the state machine returns to IDLE immediately. Slave responses to pre-reset requests are the system's responsibility and are not filtered.
- Throughput: at most one pair per 3 cycles with 1-cycle slave latency (IDLE, REQ, WAIT).

Test Plan:
- Reset release, pc=32'hbfc00000, addr_ok in cycle 2, data_ok in cycle 3 with rdata={32'h2,32'h1} -> ok1=ok2=1, f_inst_1=1, f_inst_2=2; next cycle pc=32'hbfc00008.
- pc=32'hbfc00004 -> inst_addr=32'hbfc00000; on data_ok, ok1=1, ok2=0, f_inst_1=word1; pc advances to 32'hbfc00008.
- Redirect asserted in WAIT, with data_ok arriving in the same cycle -> no ok; state IDLE. Next request uses the redirect target, e.g. 32'h80001000.
- Redirect in REQ while addr_ok is delayed 3 cycles -> inst_addr held stable; after addr_ok, state DISCARD; data_ok is dropped; the following request uses the target address.
- stall=1 when data_ok arrives, stall held 4 cycles -> ok stays 0 and pc is unchanged. On stall release: ok1/ok2 asserted with the buffered words; pc+8 loaded next cycle.
- next_pc=32'hbfc00002 loaded -> fetch_adel=1, inst_req stays 0. Redirect to 32'hbfc00380 -> fetch_adel=0, and a request to 32'hbfc00380 is issued after the IDLE bubble.
